// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and sizing helpers for the sequential restoring divider.
//   div_state_t : controller states (IDLE, CALC, DONE)
//   DIV_WIDTH   : default operand width of the arithmetic library
//   CNT_W       : iteration counter width for the default operand width
//   cnt_width() : iteration counter width for any operand width
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // The counter runs 0 .. WIDTH-1, so $clog2(WIDTH) bits are enough.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_trial_sub.sv
// ---------------------------------------------------------------------------
// div_trial_sub
// Combinational (WIDTH+1)-bit trial subtraction r - {1'b0, divisor}, built
// as r + ~{1'b0, divisor} + 1 with 4-bit carry-lookahead groups that are
// chained group to group, like the library adders.
//   r       in   WIDTH+1  shifted partial remainder
//   divisor in   WIDTH    unsigned divisor
//   diff    out  WIDTH    low WIDTH bits of r - divisor
//   borrow  out  1        1 when r < divisor (inverted carry out)
// The top difference bit is not produced: whenever the subtraction does not
// borrow, the result is below the divisor and fits in WIDTH bits.
// ---------------------------------------------------------------------------
module div_trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int N = WIDTH + 1;

    logic [N-1:0] op_b;
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;
    logic         term;
    logic         look;

    assign op_b = ~{1'b0, divisor};
    assign gen  = r & op_b;
    assign prop = r ^ op_b;

    // Inside a group every carry is the full lookahead expression of the
    // group carry-in; only the group carry-in itself comes from the group
    // below. The last group may be shorter than four bits.
    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        carry    = '0;
        term     = 1'b0;
        look     = 1'b0;
        carry[0] = 1'b1;              // +1 of the two's complement
        for (int base = 0; base < N; base += 4) begin
            for (int j = 0; j < 4; j++) begin
                if (base + j < N) begin
                    term = carry[base];
                    for (int k = base; k <= base + j; k++) term = term & prop[k];
                    look = term;
                    for (int k = base; k <= base + j; k++) begin
                        term = gen[k];
                        for (int m = k + 1; m <= base + j; m++) term = term & prop[m];
                        look = look | term;
                    end
                    carry[base+j+1] = look;
                end
            end
        end
    end

    assign diff   = prop[WIDTH-1:0] ^ carry[WIDTH-1:0];
    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock,
// valid/ready handshake on both sides. All outputs come from registers.
//   clk         in   1      clock, all updates on posedge
//   rst_n       in   1      synchronous active-low reset
//   in_valid    in   1      dividend/divisor valid
//   in_ready    out  1      divider idle, can accept an operation
//   dividend    in   WIDTH  unsigned dividend
//   divisor     in   WIDTH  unsigned divisor
//   out_valid   out  1      quotient/remainder/div_by_zero valid
//   out_ready   in   1      consumer takes the result
//   quotient    out  WIDTH  unsigned quotient ({WIDTH{1}} on divide by zero)
//   remainder   out  WIDTH  unsigned remainder (dividend on divide by zero)
//   div_by_zero out  1      divisor was zero for this result
// Latency: WIDTH cycles from accept to out_valid, 0 for a zero divisor.
// ---------------------------------------------------------------------------
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH       // must be >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(WIDTH - 1);

    div_state_t          state;
    div_state_t          state_next;
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    divisor_r;
    // The partial remainder is always below the divisor between iterations,
    // so its top bit would be constant zero; it only exists in the shift.
    logic [WIDTH-1:0]    rem_acc;
    logic [WIDTH-1:0]    q_acc;

    logic [WIDTH:0]      shifted;
    logic [WIDTH-1:0]    trial_diff;
    logic                trial_borrow;
    logic [WIDTH-1:0]    rem_step;
    logic [WIDTH-1:0]    q_step;

    logic accept;
    logic last_iter;

    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (state == CALC) && (cnt == LAST_ITER);

    // Datapath of one iteration: shift the next dividend bit in, trial
    // subtract, keep the difference only when it did not go negative.
    assign shifted  = {rem_acc, q_acc[WIDTH-1]};
    assign rem_step = trial_borrow ? shifted[WIDTH-1:0] : trial_diff;
    assign q_step   = {q_acc[WIDTH-2:0], ~trial_borrow};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .r       (shifted),
        .divisor (divisor_r),
        .diff    (trial_diff),
        .borrow  (trial_borrow)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = (divisor != '0) ? CALC : DONE;
            CALC:    if (cnt == LAST_ITER) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode the registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Iteration registers and result registers. Operands are sampled only at
    // the accept edge; results are held for as long as DONE lasts.
    // NOTE: the datapath registers are reset as well, so a reset mid-operation
    // leaves no trace of the aborted partial result on the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            divisor_r   <= '0;
            rem_acc     <= '0;
            q_acc       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            divisor_r <= divisor;
            rem_acc   <= '0;
            q_acc     <= dividend;
            cnt       <= '0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            rem_acc <= rem_step;
            q_acc   <= q_step;
            cnt     <= cnt + 1'b1;
            if (last_iter) begin
                quotient  <= q_step;
                remainder <= rem_step;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
// Self-checking bench for seq_restoring_divider at WIDTH=8: a table of
// directed operations with hand-computed results, hand-written sequences for
// backpressure and reset mid-operation, and a batch of random operations
// with random handshake delays against a / b and a % b.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int W = 8;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec  = 0;
    int n_miss = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one operation, wait for its result, release it after
    // ready_delay cycles of backpressure. lat counts edges from accept to
    // out_valid; TIMEOUT means the result never appeared.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int ready_delay,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat);
        int guard = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && guard < TIMEOUT) begin
            tick();
            guard++;
        end
        check("in_ready before accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        dividend = $urandom_range(0, 255);   // must not matter after accept
        divisor  = $urandom_range(0, 255);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        repeat (ready_delay) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] q, r;
        logic         dbz;
        int           lat;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
        vecs[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[4]  = '{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 0};
        vecs[5]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 0};
        vecs[6]  = '{8'd50,  8'd5,   8'd10,  8'd0,   1'b0, 8};
        vecs[7]  = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8};
        vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};
        vecs[9]  = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0, 8};
        vecs[10] = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0, 8};
        vecs[11] = '{8'd171, 8'd13,  8'd13,  8'd2,   1'b0, 8};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("reset in_ready",    {31'd0, in_ready},    32'd1);
        check("reset out_valid",   {31'd0, out_valid},   32'd0);
        check("reset quotient",    {24'd0, quotient},    32'd0);
        check("reset remainder",   {24'd0, remainder},   32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, i % 3, q, r, dbz, lat);
            check($sformatf("vec%0d quotient", i),  {24'd0, q},   {24'd0, vecs[i].q});
            check($sformatf("vec%0d remainder", i), {24'd0, r},   {24'd0, vecs[i].r});
            check($sformatf("vec%0d dbz", i),       {31'd0, dbz}, {31'd0, vecs[i].dbz});
            check($sformatf("vec%0d latency", i),   lat,          vecs[i].lat);
            check($sformatf("vec%0d released", i),  {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: hold a finished 100/7 while a new op is offered.
        in_valid = 1'b1; dividend = 8'd100; divisor = 8'd7;
        tick();
        dividend = 8'd9; divisor = 8'd3;      // offered during CALC: ignored
        repeat (8) tick();
        check("bp out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
            check("bp hold in_ready",  {31'd0, in_ready},  32'd0);
            check("bp hold quotient",  {24'd0, quotient},  32'd14);
            check("bp hold remainder", {24'd0, remainder}, 32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp idle in_ready",  {31'd0, in_ready},  32'd1);
        check("bp idle out_valid", {31'd0, out_valid}, 32'd0);
        tick();                                // 9/3 accepted here
        in_valid = 1'b0;
        check("bp new op busy", {31'd0, in_ready}, 32'd0);
        repeat (8) tick();
        check("bp new out_valid", {31'd0, out_valid}, 32'd1);
        check("bp new quotient",  {24'd0, quotient},  32'd3);
        check("bp new remainder", {24'd0, remainder}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset at the fourth iteration edge of 100/7.
        in_valid = 1'b1; dividend = 8'd100; divisor = 8'd7;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort in_ready",  {31'd0, in_ready},  32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort quotient",  {24'd0, quotient},  32'd0);
        check("abort remainder", {24'd0, remainder}, 32'd0);
        do_op(8'd50, 8'd5, 0, q, r, dbz, lat);
        check("after abort quotient",  {24'd0, q}, 32'd10);
        check("after abort remainder", {24'd0, r}, 32'd0);
        check("after abort latency",   lat,        8);

        // Random operations with random handshake delays.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a, b, eq, er;
            a = W'($urandom_range(0, 255));
            b = (i % 16 == 0) ? 8'd0 : W'($urandom_range(0, 255));
            eq = (b == 0) ? 8'hFF : a / b;
            er = (b == 0) ? a : a % b;
            repeat ($urandom_range(0, 2)) tick();
            do_op(a, b, $urandom_range(0, 3), q, r, dbz, lat);
            check($sformatf("rnd %0d/%0d q", a, b), {24'd0, q},   {24'd0, eq});
            check($sformatf("rnd %0d/%0d r", a, b), {24'd0, r},   {24'd0, er});
            check($sformatf("rnd %0d/%0d dbz", a, b), {31'd0, dbz}, {31'd0, (b == 0)});
            check($sformatf("rnd %0d/%0d lat", a, b), lat, (b == 0) ? 0 : 8);
            check("rnd single result", {31'd0, out_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
